aes_comp_decipher_block: RTL and testbench
==========================================

// Module: aes_comp_decipher_block
// PURPOSE
//   Iterative AES inverse cipher for one 128-bit block, AES-128 or AES-256, decryption side
//   of the core. Takes the round key for the current round from the shared key memory, indexed
//   by the round output. Runs SubBytes through an external inverse S-box, one 32-bit word per
//   cycle. Ends with the round-0 AddRoundKey; no MixColumns in the last round.
// PARAMETERS
//   (none) -- round count selected at run time by keylen: 10 (AES-128), 14 (AES-256)
// PORTS
//   clk           in   1    clock; all state updates on rising edge
//   reset         in   1    synchronous, active-high reset
//   next          in   1    start pulse; sampled only in IDLE
//   keylen        in   1    0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); held stable while busy
//   round         out  4    current round index (round_ctr_reg), selects round_key
//   round_key     in   128  combinational key for index `round`
//   invsboxw      out  32   word to inverse S-box
//   new_invsboxw  in   32   combinational InvSubBytes(invsboxw)
//   block         in   128  ciphertext; held stable until the INIT cycle completes
//   new_block     out  128  state register {w0,w1,w2,w3}; plaintext when ready rises
//   ready         out  1    1 = idle / result valid
// BEHAVIOUR
//   Reset (synchronous, highest priority, any state):
//     ctrl=IDLE, w0..w3=0, sword_ctr=0, round_ctr=0, ready=1.
//     Outputs after reset: new_block=0, round=0, invsboxw=0, ready=1.
//     Reset mid-operation aborts the block; no partial result is kept.
//   FSM states: IDLE, INIT, SBOX, MAIN.
//   IDLE:
//     next=1 -> round_ctr<=Nr, ready<=0, go to INIT.
//     next=0 -> hold all registers.
//   INIT:
//     state <= InvShiftRows(block ^ round_key), using key index Nr.
//     round_ctr<=Nr-1, sword_ctr<=0, go to SBOX.
//   SBOX (4 cycles):
//     invsboxw = w[sword_ctr] (w0 first); w[sword_ctr] <= new_invsboxw; sword_ctr++.
//     After the sword_ctr==3 cycle, go to MAIN.
//   MAIN:
//     Always: sword_ctr<=0.
//     round_ctr>0: state <= InvShiftRows(InvMixColumns(state ^ round_key)); round_ctr--; go to SBOX.
//     round_ctr==0: state <= state ^ round_key; ready<=1; go to IDLE; round stays 0.
//   invsboxw = 32'h0 in every state except SBOX.
//   Latency: 2 + 5*Nr rising edges from the edge sampling next to ready=1.
//     AES-128: 52 cycles. AES-256: 72 cycles.
//   new_block is stable from the edge that sets ready until the next start.
//   next while busy (ready=0) is ignored; no queuing.
//   next in the same cycle as ready rises is ignored; IDLE samples it from the next cycle.
//   Counters: sword_ctr is 2 bits and wraps 3->0; round_ctr is 4 bits, never below 0.
//   Byte order is FIPS-197: w0 = column 0 = bits [127:96].
// TESTING
//   T1 FIPS-197 C.1:
//     keylen=0, key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, next pulse
//     -> 52 cycles later ready=1, new_block = 00112233445566778899aabbccddeeff.
//   T2 FIPS-197 C.3:
//     keylen=1, key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089
//     -> ready after 72 cycles, new_block = 00112233445566778899aabbccddeeff.
//   T3 round sequence:
//     round = 10 in INIT, then 9..0 in successive MAINs (AES-128).
//     invsboxw nonzero only in SBOX; it visits w0..w3 in order each round.
//   T4 next pulses while busy are ignored; the T1 result and latency are unchanged.
//     Back-to-back blocks, next asserted the cycle after ready rises -> both decrypt correctly.
//   T5 reset asserted at cycle 20 of T1:
//     next edge: ready=1, new_block=0, round=0, invsboxw=0.
//     A fresh T1 then passes.
//   T6 round trip with the encipher block:
//     1000 random key/plaintext pairs, both key lengths -> decrypt(encrypt(p)) == p.

Source files
------------

// File: rtl/aes_comp_decipher_block_if.sv
// Decipher-block bus: start/ready handshake, round-key fetch and inverse S-box
// word exchange.
//   next          start pulse (sampled while idle)
//   keylen        0 = AES-128, 1 = AES-256
//   round         round index used to fetch round_key
//   round_key     round key for index `round`
//   invsboxw      word sent to the inverse S-box
//   new_invsboxw  InvSubBytes(invsboxw), combinational
//   block         ciphertext input
//   new_block     state / plaintext output
//   ready         idle / result valid
interface aes_comp_decipher_block_if;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ROUND_W = 4;

  logic               next;
  logic               keylen;
  logic [ROUND_W-1:0] round;
  logic [BLOCK_W-1:0] round_key;
  logic [WORD_W-1:0]  invsboxw;
  logic [WORD_W-1:0]  new_invsboxw;
  logic [BLOCK_W-1:0] block;
  logic [BLOCK_W-1:0] new_block;
  logic               ready;

  // Environment side: starts blocks, serves round keys and S-box lookups.
  modport master (
    output next, keylen, round_key, new_invsboxw, block,
    input  round, invsboxw, new_block, ready
  );

  // Decipher core side.
  modport slave (
    input  next, keylen, round_key, new_invsboxw, block,
    output round, invsboxw, new_block, ready
  );
endinterface

// File: rtl/aes_comp_decipher_block.sv
// Iterative AES-128/AES-256 inverse cipher for one 128-bit block.
// Round keys are fetched from shared key memory by the `round` output; the
// InvSubBytes step goes through an external inverse S-box one word per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    aes_comp_decipher_block_if.slave (handshake, key fetch, S-box, data)
module aes_comp_decipher_block (
  input  logic                      clk,
  input  logic                      reset,
  aes_comp_decipher_block_if.slave  bus
);

  localparam int unsigned BLOCK_W  = 128;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ROUND_W  = 4;
  localparam int unsigned SWORD_W  = 2;
  localparam logic [ROUND_W-1:0] NR_128 = ROUND_W'(10);
  localparam logic [ROUND_W-1:0] NR_256 = ROUND_W'(14);

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_INIT,
    CTRL_SBOX,
    CTRL_MAIN
  } ctrl_t;

  ctrl_t               ctrl_reg, ctrl_new;
  logic [BLOCK_W-1:0]  state_reg, state_new;
  logic [SWORD_W-1:0]  sword_ctr_reg, sword_ctr_new;
  logic [ROUND_W-1:0]  round_ctr_reg, round_ctr_new;
  logic                ready_reg, ready_new;
  logic [WORD_W-1:0]   invsboxw_c;

  logic [ROUND_W-1:0]  num_rounds;
  logic [BLOCK_W-1:0]  addkey_block;

  // GF(2^8) multiply by 2 with the AES reduction polynomial.
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
  endfunction

  // InvMixColumns on one column.
  function automatic logic [WORD_W-1:0] inv_mix_word(input logic [WORD_W-1:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
            gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    return {inv_mix_word(s[127:96]), inv_mix_word(s[95:64]),
            inv_mix_word(s[63:32]),  inv_mix_word(s[31:0])};
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [WORD_W-1:0] w0, w1, w2, w3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  assign num_rounds   = bus.keylen ? NR_256 : NR_128;
  assign addkey_block = state_reg ^ bus.round_key;

  assign bus.round     = round_ctr_reg;
  assign bus.new_block = state_reg;
  assign bus.ready     = ready_reg;
  assign bus.invsboxw  = invsboxw_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg      <= CTRL_IDLE;
      state_reg     <= '0;
      sword_ctr_reg <= '0;
      round_ctr_reg <= '0;
      ready_reg     <= 1'b1;
    end else begin
      ctrl_reg      <= ctrl_new;
      state_reg     <= state_new;
      sword_ctr_reg <= sword_ctr_new;
      round_ctr_reg <= round_ctr_new;
      ready_reg     <= ready_new;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    ctrl_new      = ctrl_reg;
    state_new     = state_reg;
    sword_ctr_new = sword_ctr_reg;
    round_ctr_new = round_ctr_reg;
    ready_new     = ready_reg;
    invsboxw_c    = '0;

    case (ctrl_reg)
      CTRL_IDLE: begin
        if (bus.next) begin
          round_ctr_new = num_rounds;
          ready_new     = 1'b0;
          ctrl_new      = CTRL_INIT;
        end
      end

      // Key index Nr is on `round` during this cycle.
      CTRL_INIT: begin
        state_new     = inv_shift_rows(bus.block ^ bus.round_key);
        round_ctr_new = round_ctr_reg - ROUND_W'(1);
        sword_ctr_new = '0;
        ctrl_new      = CTRL_SBOX;
      end

      // One column per cycle through the external inverse S-box, w0 first.
      CTRL_SBOX: begin
        case (sword_ctr_reg)
          2'd0: begin
            invsboxw_c        = state_reg[127:96];
            state_new[127:96] = bus.new_invsboxw;
          end
          2'd1: begin
            invsboxw_c       = state_reg[95:64];
            state_new[95:64] = bus.new_invsboxw;
          end
          2'd2: begin
            invsboxw_c       = state_reg[63:32];
            state_new[63:32] = bus.new_invsboxw;
          end
          default: begin
            invsboxw_c      = state_reg[31:0];
            state_new[31:0] = bus.new_invsboxw;
          end
        endcase
        sword_ctr_new = sword_ctr_reg + SWORD_W'(1);
        if (sword_ctr_reg == SWORD_W'(3)) begin
          ctrl_new = CTRL_MAIN;
        end
      end

      // InvShiftRows of the next round is folded in here; it commutes with
      // the bytewise InvSubBytes that follows.
      CTRL_MAIN: begin
        sword_ctr_new = '0;
        if (round_ctr_reg != '0) begin
          state_new     = inv_shift_rows(inv_mix_columns(addkey_block));
          round_ctr_new = round_ctr_reg - ROUND_W'(1);
          ctrl_new      = CTRL_SBOX;
        end else begin
          state_new = addkey_block;
          ready_new = 1'b1;
          ctrl_new  = CTRL_IDLE;
        end
      end

      default: begin
        ctrl_new = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_comp_decipher_block.sv
// Bench for aes_comp_decipher_block: serves round keys and inverse S-box
// lookups from a software AES model, and checks plaintext, latency, round
// sequencing and S-box traffic against encryption-side intermediate states.
module tb_aes_comp_decipher_block;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  aes_comp_decipher_block_if ifc ();

  aes_comp_decipher_block dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_tab  [16];
  logic [127:0] st_hist [16];

  int checks = 0;
  int passed = 0;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // Key memory and inverse S-box seen by the DUT.
  assign ifc.round_key    = rk_tab[ifc.round];
  assign ifc.new_invsboxw = {isb[ifc.invsboxw[31:24]], isb[ifc.invsboxw[23:16]],
                             isb[ifc.invsboxw[15:8]],  isb[ifc.invsboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, t, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv;
      t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s = s ^ t;
      end
      s = s ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes128(input logic [127:0] x);
    logic [127:0] y;
    for (int k = 0; k < 16; k++) y[127-8*k -: 8] = sb[x[127-8*k -: 8]];
    return y;
  endfunction

  // Byte k = 4*column + row, byte 0 in bits [127:120].
  function automatic logic [127:0] shift_rows128(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] mix_columns128(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = x[127-8*(4*c+r) -: 8];
      y[127-8*(4*c+0) -: 8] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
      y[127-8*(4*c+1) -: 8] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
      y[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
      y[127-8*(4*c+3) -: 8] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
    end
    return y;
  endfunction

  // FIPS-197 key expansion into the round-key table.
  task automatic set_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk   = kl ? 8 : 4;
    nr   = kl ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Forward cipher; st_hist[r] is the state after AddRoundKey of round r.
  task automatic aes_encrypt(input logic [127:0] pt, input logic kl,
                             output logic [127:0] ct);
    logic [127:0] st;
    int nr;
    nr = kl ? 14 : 10;
    st = pt ^ rk_tab[0];
    st_hist[0] = st;
    for (int r = 1; r <= nr; r++) begin
      st = shift_rows128(sub_bytes128(st));
      if (r < nr) st = mix_columns128(st);
      st = st ^ rk_tab[r];
      st_hist[r] = st;
    end
    ct = st;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round/S-box expectations for cycle `cyc` after the start edge. The state
  // entering decryption round rr's S-box pass is SubBytes of the encryption
  // state after AddRoundKey rr.
  task automatic trace_check(input string tag, input int nr, input int cyc);
    logic [127:0] sbst;
    int j, rr;
    if (cyc == 1) begin
      chk($sformatf("%s init round", tag), 128'(ifc.round), 128'(nr));
      chk($sformatf("%s init invsboxw", tag), 128'(ifc.invsboxw), 128'h0);
    end else begin
      j  = (cyc - 2) % 5;
      rr = nr - 1 - (cyc - 2) / 5;
      chk($sformatf("%s c%0d round", tag, cyc), 128'(ifc.round), 128'(rr));
      if (j < 4) begin
        sbst = sub_bytes128(st_hist[rr]);
        chk($sformatf("%s c%0d invsboxw", tag, cyc), 128'(ifc.invsboxw),
            128'(sbst[127-32*j -: 32]));
      end else begin
        chk($sformatf("%s c%0d invsboxw", tag, cyc), 128'(ifc.invsboxw), 128'h0);
      end
    end
  endtask

  // One decryption: start pulse, bounded wait for ready, latency and result.
  task automatic run_block(input string tag, input logic kl, input logic [127:0] ct,
                           input logic [127:0] pt, input bit trace, input bit noisy);
    int nr, lat, cyc;
    nr  = kl ? 14 : 10;
    lat = 2 + 5 * nr;
    ifc.keylen = kl;
    ifc.block  = ct;
    ifc.next   = 1'b1;
    tick();
    ifc.next = 1'b0;
    cyc = 1;
    while (ifc.ready !== 1'b1 && cyc < 200) begin
      if (cyc == 2) ifc.block = {$urandom, $urandom, $urandom, $urandom};
      if (trace && cyc < lat) trace_check(tag, nr, cyc);
      if (noisy) ifc.next = (cyc % 6 == 1) || (cyc == lat - 1);
      tick();
      cyc++;
    end
    ifc.next = 1'b0;
    chk({tag, " latency"}, 128'(cyc), 128'(lat));
    chk({tag, " plaintext"}, ifc.new_block, pt);
    if (trace) begin
      chk({tag, " done round"}, 128'(ifc.round), 128'h0);
      chk({tag, " done invsboxw"}, 128'(ifc.invsboxw), 128'h0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct_m, pt_r;
    logic [255:0] key_r;
    logic         kl;

    reset      = 1'b1;
    ifc.next   = 1'b0;
    ifc.keylen = 1'b0;
    ifc.block  = '0;
    for (int r = 0; r < 16; r++) rk_tab[r] = '0;
    build_sbox();
    tick();
    tick();

    chk("reset ready", 128'(ifc.ready), 128'h1);
    chk("reset new_block", ifc.new_block, 128'h0);
    chk("reset round", 128'(ifc.round), 128'h0);
    chk("reset invsboxw", 128'(ifc.invsboxw), 128'h0);
    reset = 1'b0;
    tick();

    // T1 / T3: AES-128 known answer with full round and S-box trace.
    set_key(KEY_128, 1'b0);
    aes_encrypt(PT_FIPS, 1'b0, ct_m);
    chk("T1 model ct", ct_m, CT_128);
    run_block("T1", 1'b0, CT_128, PT_FIPS, 1'b1, 1'b0);

    // T2: AES-256 known answer with trace.
    set_key(KEY_256, 1'b1);
    aes_encrypt(PT_FIPS, 1'b1, ct_m);
    chk("T2 model ct", ct_m, CT_256);
    run_block("T2", 1'b1, CT_256, PT_FIPS, 1'b1, 1'b0);

    // T4: start pulses while busy, including at the edge where ready rises.
    set_key(KEY_128, 1'b0);
    run_block("T4 busy", 1'b0, CT_128, PT_FIPS, 1'b0, 1'b1);
    tick();
    chk("T4 no restart ready", 128'(ifc.ready), 128'h1);
    chk("T4 held new_block", ifc.new_block, PT_FIPS);

    // T4: back-to-back blocks.
    pt_r = {$urandom, $urandom, $urandom, $urandom};
    aes_encrypt(pt_r, 1'b0, ct_m);
    run_block("T4 b2b a", 1'b0, CT_128, PT_FIPS, 1'b0, 1'b0);
    run_block("T4 b2b b", 1'b0, ct_m, pt_r, 1'b0, 1'b0);

    // T5: reset mid-block, then a clean rerun.
    ifc.keylen = 1'b0;
    ifc.block  = CT_128;
    ifc.next   = 1'b1;
    tick();
    ifc.next = 1'b0;
    repeat (19) tick();
    chk("T5 busy before reset", 128'(ifc.ready), 128'h0);
    reset = 1'b1;
    tick();
    chk("T5 reset ready", 128'(ifc.ready), 128'h1);
    chk("T5 reset new_block", ifc.new_block, 128'h0);
    chk("T5 reset round", 128'(ifc.round), 128'h0);
    chk("T5 reset invsboxw", 128'(ifc.invsboxw), 128'h0);
    reset = 1'b0;
    tick();
    run_block("T5 rerun", 1'b0, CT_128, PT_FIPS, 1'b0, 1'b0);

    // T6: random round trips over both key lengths.
    for (int i = 0; i < 1000; i++) begin
      kl    = 1'(i % 2);
      key_r = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key_r, kl);
      aes_encrypt(pt_r, kl, ct_m);
      run_block($sformatf("T6 #%0d", i), kl, ct_m, pt_r, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
